// File: rtl/seg7_pkg.sv
// Shared seven-segment types and the hex-digit segment table.
// Table entries are active-low and listed in segment order a..g.
package seg7_pkg;

  typedef logic [0:6] seg7_t;

  // All segments dark, active-low form
  localparam seg7_t SEG_OFF = 7'b1111111;

  // X/Z inputs fall through to the default so they stay visible in simulation.
  function automatic seg7_t seg7_lookup(input logic [3:0] value);
    case (value)
      4'h0:    seg7_lookup = 7'b0000001;
      4'h1:    seg7_lookup = 7'b1001111;
      4'h2:    seg7_lookup = 7'b0010010;
      4'h3:    seg7_lookup = 7'b0000110;
      4'h4:    seg7_lookup = 7'b1001100;
      4'h5:    seg7_lookup = 7'b0100100;
      4'h6:    seg7_lookup = 7'b0100000;
      4'h7:    seg7_lookup = 7'b0001111;
      4'h8:    seg7_lookup = 7'b0000000;
      4'h9:    seg7_lookup = 7'b0000100;
      4'hA:    seg7_lookup = 7'b0001000;
      4'hB:    seg7_lookup = 7'b1100000;
      4'hC:    seg7_lookup = 7'b0110001;
      4'hD:    seg7_lookup = 7'b1000010;
      4'hE:    seg7_lookup = 7'b0110000;
      4'hF:    seg7_lookup = 7'b0111000;
      default: seg7_lookup = 'x;
    endcase
  endfunction

endpackage

// File: rtl/seg7_lut.sv
// Combinational hex-to-segment lookup.
// The output is in active-low form.
module seg7_lut
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  output logic [0:6] seg
);

  assign seg = seg7_lookup(value);

endmodule

// File: rtl/encoder.sv
// Registered hex-digit encoder for one seven-segment digit.
// Applies the panel polarity and holds the segments dark while reset is asserted.
module encoder
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] binNumber,
  output logic [0:6] cathodeNumber
);

  localparam seg7_t RST_VAL = ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;

  seg7_t lut_seg;
  seg7_t cathode_d;
  seg7_t cathode_q;

  seg7_lut u_lut (
    .value (binNumber),
    .seg   (lut_seg)
  );

  always_comb begin
    cathode_d = ACTIVE_LOW ? lut_seg : ~lut_seg;
  end

  // The output register keeps glitches from the lookup off the pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cathode_q <= RST_VAL;
    else     cathode_q <= cathode_d;
  end

  assign cathodeNumber = cathode_q;

endmodule

// File: tb/tb_encoder.sv
// Bench for encoder: directed reset, sweep, latency and polarity steps, then random digits.
// The reference model builds each pattern from the set of lit segment letters.
module tb_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] binNumber = 4'h8;
  logic [0:6] cath_al;
  logic [0:6] cath_ah;

  int total  = 0;
  int passed = 0;

  string lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                      "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  encoder #(.ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .binNumber(binNumber), .cathodeNumber(cath_al)
  );

  encoder #(.ACTIVE_LOW(1'b0)) dut_ah (
    .clk(clk), .rst(rst), .binNumber(binNumber), .cathodeNumber(cath_ah)
  );

  always #25 clk = ~clk;

  function automatic logic [0:6] model(input int v, input bit active_low);
    logic [0:6] r;
    string s;
    r = active_low ? 7'b1111111 : 7'b0000000;
    s = lit[v];
    for (int k = 0; k < s.len(); k++) r[s[k] - 8'd97] = active_low ? 1'b0 : 1'b1;
    return r;
  endfunction

  task automatic check(input string tag, input logic [0:6] obs, input logic [0:6] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic check_both(input string tag, input int v);
    check({tag, "_al"}, cath_al, model(v, 1'b1));
    check({tag, "_ah"}, cath_ah, model(v, 1'b0));
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int prev;
    int v;

    // Asynchronous reset with no clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_async_al", cath_al, 7'b1111111);
    check("rst_async_ah", cath_ah, 7'b0000000);
    edge_sample();
    edge_sample();
    check("rst_hold_al", cath_al, 7'b1111111);
    check("rst_hold_ah", cath_ah, 7'b0000000);

    // Full sweep 0..F then wrap to 0
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      binNumber = 4'(i);
      edge_sample();
      check_both($sformatf("sweep_%0h", i), i);
      @(negedge clk);
    end
    check("sweep_F_const", cath_al, 7'b0111000);
    binNumber = 4'h0;
    edge_sample();
    check("wrap_0", cath_al, 7'b0000001);

    // Mid-cycle input change must not reach the output before the edge
    @(negedge clk);
    binNumber = 4'h1;
    edge_sample();
    check("lat_1", cath_al, 7'b1001111);
    check("pol_1_ah", cath_ah, 7'b0110000);
    @(negedge clk);
    binNumber = 4'h2;
    #5;
    check("lat_hold", cath_al, 7'b1001111);
    edge_sample();
    check("lat_2", cath_al, 7'b0010010);

    // Mid-run reset and release
    @(negedge clk);
    binNumber = 4'h4;
    edge_sample();
    check("pre_rst_4", cath_al, 7'b1001100);
    #10 rst = 1'b1;
    #1;
    check("midrst_al", cath_al, 7'b1111111);
    check("midrst_ah", cath_ah, 7'b0000000);
    @(negedge clk);
    binNumber = 4'h5;
    rst = 1'b0;
    #1;
    check("rel_before_edge", cath_al, 7'b1111111);
    edge_sample();
    check("rel_5", cath_al, 7'b0100100);
    prev = 5;

    // Random digits, one per cycle, with one-cycle lag checked before each edge
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      v = int'($urandom_range(0, 15));
      binNumber = 4'(v);
      #1;
      check_both("rnd_lag", prev);
      edge_sample();
      check_both("rnd", v);
      prev = v;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
